// File: rtl/vector_dot_stream.sv
`default_nettype none
// ============================================================================
// Module   : vector_dot_stream
// Purpose  : Streams two vectors from external memories NO_OF_UNITS lanes per
//            chunk and produces their signed dot product.
//            Pipeline: memory read (1 cycle) -> lane products -> adder tree
//            -> accumulator / result register.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-high reset
//            start        - one-cycle request; accepted only while idle
//            rd_en        - chunk read strobe to both vector memories
//            rd_addr      - chunk index 0..CHUNKS-1
//            rd_data_a/b  - chunk data; lane i at [i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
//            result       - dot product, held until the next result_valid
//            result_valid - one-cycle pulse for a new result
//            busy         - high from start acceptance through result_valid
//            finish       - sticky completion flag, cleared by the next start
//            overflow     - result was clamped (saturating build only)
// Options  : define VXV_SATURATE_EN to clamp out-of-range sums; otherwise the
//            result wraps to the low ELEMENT_WIDTH bits and overflow is 0.
// Revision : 1.0 - initial release
// ============================================================================
module vector_dot_stream #(
    parameter int NOE           = 10,
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32,
    parameter int ACC_WIDTH     = 2*ELEMENT_WIDTH+16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 rd_en,
    output logic [11:0]                          rd_addr,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data_a,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data_b,
    output logic [ELEMENT_WIDTH-1:0]             result,
    output logic                                 result_valid,
    output logic                                 busy,
    output logic                                 finish,
    output logic                                 overflow
);

    localparam int          c_chunks     = (NOE + NO_OF_UNITS - 1) / NO_OF_UNITS;
    localparam int          c_last_lanes = NOE - (c_chunks - 1) * NO_OF_UNITS;
    localparam logic [11:0] c_last_addr  = 12'(c_chunks - 1);
    localparam int          c_pw         = 2 * ELEMENT_WIDTH;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]  r_state, w_state_next;
    logic        w_accept, w_fetch;

    logic [11:0] r_chunk;
    logic        r_rd_en, r_rd_last;
    logic [11:0] r_rd_addr;

    logic        r_dat_vld, r_dat_last;
    logic [NO_OF_UNITS*c_pw-1:0] w_prod, r_prod;
    logic        r_prod_vld, r_prod_last;
    logic signed [ACC_WIDTH-1:0] w_tree, r_sum;
    logic        r_sum_vld, r_sum_last;
    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_sum;

    logic [ELEMENT_WIDTH-1:0] w_res, r_result;
    logic        w_ovf, r_overflow, r_result_valid, r_finish;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_fetch;
                    w_accept     = 1'b1;
                end
            end
            c_st_fetch: begin
                if (r_chunk == c_last_addr) w_state_next = c_st_drain;
            end
            // Leave DRAIN on the edge that launches result_valid, so DONE
            // coincides with the pulse and a start then is ignored.
            c_st_drain: begin
                if (r_sum_vld && r_sum_last) w_state_next = c_st_done;
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    assign w_fetch = (r_state == c_st_fetch);

    // ---------------------------------------------------- read sequencing
    // The strobe is registered from the FETCH state, so it trails the state
    // by one cycle; the last-chunk tag travels down the pipeline with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chunk   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_chunk   <= w_fetch ? r_chunk + 12'd1 : 12'd0;
            r_rd_en   <= w_fetch;
            r_rd_last <= w_fetch && (r_chunk == c_last_addr);
            if (w_fetch) r_rd_addr <= r_chunk;
        end
    end

    // -------------------------------------------------------- lane products
    for (genvar gi = 0; gi < NO_OF_UNITS; gi++) begin : g_lane
        localparam bit c_pad = (gi >= c_last_lanes);
        logic [c_pw-1:0] w_a_ext, w_b_ext;
        assign w_a_ext = {{ELEMENT_WIDTH{rd_data_a[gi*ELEMENT_WIDTH+ELEMENT_WIDTH-1]}},
                          rd_data_a[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH]};
        assign w_b_ext = {{ELEMENT_WIDTH{rd_data_b[gi*ELEMENT_WIDTH+ELEMENT_WIDTH-1]}},
                          rd_data_b[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH]};
        // Lanes beyond NOE in the final chunk contribute nothing, whatever
        // the memory holds there.
        assign w_prod[gi*c_pw +: c_pw] = (c_pad && r_dat_last) ? '0 : w_a_ext * w_b_ext;
    end

    // ------------------------------------------------------------ adder tree
    always_comb begin
        w_tree = '0;
        for (int i = 0; i < NO_OF_UNITS; i++) begin
            w_tree = w_tree + {{(ACC_WIDTH-c_pw){r_prod[i*c_pw+c_pw-1]}},
                               r_prod[i*c_pw +: c_pw]};
        end
    end

    assign w_acc_sum = r_acc + r_sum;

    // -------------------------------------------------- pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat_vld   <= 1'b0;
            r_dat_last  <= 1'b0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_prod_last <= 1'b0;
            r_sum       <= '0;
            r_sum_vld   <= 1'b0;
            r_sum_last  <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_dat_vld   <= r_rd_en;
            r_dat_last  <= r_rd_last;
            r_prod      <= w_prod;
            r_prod_vld  <= r_dat_vld;
            r_prod_last <= r_dat_last;
            r_sum       <= w_tree;
            r_sum_vld   <= r_prod_vld;
            r_sum_last  <= r_prod_last;
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_sum_vld) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // ------------------------------------------------------- result format
`ifdef VXV_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] c_max =
        {{(ACC_WIDTH-ELEMENT_WIDTH+1){1'b0}}, {(ELEMENT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_min =
        {{(ACC_WIDTH-ELEMENT_WIDTH+1){1'b1}}, {(ELEMENT_WIDTH-1){1'b0}}};

    always_comb begin
        w_res = w_acc_sum[ELEMENT_WIDTH-1:0];
        w_ovf = 1'b0;
        if (w_acc_sum > c_max) begin
            w_res = c_max[ELEMENT_WIDTH-1:0];
            w_ovf = 1'b1;
        end else if (w_acc_sum < c_min) begin
            w_res = c_min[ELEMENT_WIDTH-1:0];
            w_ovf = 1'b1;
        end
    end
`else
    assign w_res = w_acc_sum[ELEMENT_WIDTH-1:0];
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_finish       <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_result_valid <= r_sum_vld && r_sum_last;
            if (r_sum_vld && r_sum_last) begin
                r_result   <= w_res;
                r_overflow <= w_ovf;
                r_finish   <= 1'b1;
            end else if (w_accept) begin
                r_finish   <= 1'b0;
            end
        end
    end

    assign rd_en        = r_rd_en;
    assign rd_addr      = r_rd_addr;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != c_st_idle);
    assign finish       = r_finish;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vector_dot_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_dot_stream
// Purpose  : Self-checking bench for vector_dot_stream (NOE=10, 8 lanes,
//            32-bit elements). Expected results are queued at stimulus time
//            and popped by a monitor whenever result_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_dot_stream;

    localparam int NOE   = 10;
    localparam int UNITS = 8;
    localparam int EW    = 32;
`ifdef VXV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  rd_en;
    logic [11:0]           rd_addr;
    logic [UNITS*EW-1:0]   rd_data_a, rd_data_b;
    logic [EW-1:0]         result;
    logic                  result_valid, busy, finish, overflow;

    logic [UNITS*EW-1:0]   mem_a [2];
    logic [UNITS*EW-1:0]   mem_b [2];

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q [$];

    vector_dot_stream #(
        .NOE(NOE), .NO_OF_UNITS(UNITS), .ELEMENT_WIDTH(EW), .ACC_WIDTH(2*EW+16)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .result(result), .result_valid(result_valid),
        .busy(busy), .finish(finish), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // One-cycle-latency vector memories.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr[0]];
            rd_data_b <= mem_b[rd_addr[0]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_valid actual=%0h required=none", result);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("result", result, e[31:0]);
                check("overflow", overflow, e[32]);
                check("finish_with_valid", finish, 1);
            end
        end
    end

    // kind selects the vector pattern; lanes 10..15 are padding.
    task automatic load(input int kind);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            case (kind)
                0, 1:    begin a = 32'(i + 1);     b = 32'd1;        end
                2:       begin a = -32'sd3;        b = -32'sd3;      end
                3:       begin a = 32'(i + 1 - 5); b = 32'(i + 1);   end
                4:       begin a = 32'h40000000;   b = 32'h40000000; end
                5:       begin a = 32'h40000000;   b = 32'hC0000000; end
                default: begin a = 32'(i + 1);     b = 32'hFFFFFFFF; end
            endcase
            if (i >= NOE) begin
                a = (kind == 0) ? 32'd0 : 32'h7FFFFFFF;
                b = (kind == 0) ? 32'd0 : 32'h7FFFFFFF;
            end
            mem_a[i/8][(i%8)*32 +: 32] = a;
            mem_b[i/8][(i%8)*32 +: 32] = b;
        end
    endtask

    task automatic run_op(input logic [31:0] exp_res, input logic exp_ovf, input bit inject);
        int rv_cyc   = -1;
        int last_rd  = -1;
        int nrd      = 0;
        int busy_cnt = 0;
        int rv_cnt   = 0;
        exp_q.push_back({exp_ovf, exp_res});
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check("finish_cleared_by_start", finish, 0);
                check("busy_after_start", busy, 1);
            end
            if (rd_en) begin
                check("rd_addr", rd_addr, nrd);
                nrd++;
                last_rd = cyc;
            end
            if (busy) busy_cnt++;
            if (inject && cyc == 2) start = 1'b1;
            if (result_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                if (inject) start = 1'b1;
            end
            if (rv_cyc > 0 && cyc >= rv_cyc + 3) break;
        end
        start = 1'b0;
        check("result_valid_count", rv_cnt, 1);
        check("rd_en_count", nrd, 2);
        check("latency_last_rd_to_valid", rv_cyc - last_rd, 4);
        check("busy_cycles", busy_cnt, 7);
        check("finish_sticky", finish, 1);
        check("result_held", result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_after_reset;
        reset = 1'b1;
        start = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {rd_en, rd_addr, result, result_valid, busy, finish, overflow}, 0);
        reset = 1'b0;
        @(negedge clk);

        load(0); run_op(32'd55, 1'b0, 1'b0);             // 1..10 dot ones
        load(1); run_op(32'd55, 1'b0, 1'b0);             // padding lanes masked
        load(2); run_op(32'd90, 1'b0, 1'b0);             // all -3
        load(3); run_op(32'd110, 1'b0, 1'b1);            // stray starts ignored
        load(4); run_op(SAT ? 32'h7FFFFFFF : 32'h0, SAT, 1'b0);
        load(5); run_op(SAT ? 32'h80000000 : 32'h0, SAT, 1'b0);

        // Reset while draining: nothing may come out for this operation.
        load(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_op_outputs", {rd_en, rd_addr, result, result_valid, busy, finish, overflow}, 0);
        reset = 1'b0;
        rv_after_reset = 0;
        repeat (10) begin
            @(negedge clk);
            if (result_valid) rv_after_reset++;
        end
        check("no_valid_after_abort", rv_after_reset, 0);

        load(6); run_op(32'hFFFFFFC9, 1'b0, 1'b0);        // -55 after abort

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
